dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Sequencing controller for the processor's 16-line fully associative data cache. It sits between the pipeline's load/store interface (ALU result address, store data, MemRead/MemWrite) and two resources: the cache data array and the main-memory port. It owns the tag and valid store, performs hit/miss lookup, refills read misses from memory with a round-robin victim, writes stores through to memory, and stalls the pipeline until each access completes.

## Interface
Parameters:
- LINES, 16, number of cache lines; must be a power of two.
- TAG_W, 29, tag width; the tag is addr[31:3].

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- MemRead  in  1  load request; held with addr until a cycle with done=1
- MemWrite  in  1  store request; held with addr and wdata until done=1
- addr  in  32  byte address (ALU_Result)
- wdata  in  32  store data (Read_data2)
- flush  in  1  invalidate all lines
- ReadData  out  32  load result
- stall  out  1  pipeline hold
- done  out  1  access completes this cycle
- arr_idx  out  log2(LINES)  data-array line index
- arr_we  out  1  data-array write enable
- arr_wdata  out  32  data-array write data
- arr_rdata  in  32  data-array read data; combinational from arr_idx
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data; valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

## Operation
- Policy: write-through, no write-allocate. One 32-bit word per line. addr[2:0] is ignored for matching.
- The internal state is: tag[LINES], valid[LINES], victim pointer ptr, latched request (op, addr, wdata), and FSM state.
- FSM states are IDLE, LOOKUP, REFILL and WRITE.
- **IDLE**
  - flush=1: clear all valid bits. Any request is not accepted this cycle.
  - Otherwise, if MemRead or MemWrite is high: latch the request and go to LOOKUP.
  - If both are high, the request is treated as a write.
- **LOOKUP**
  - hit = valid[i] and tag[i]==addr_q[31:3] for some i. At most one line can match.
  - arr_idx = hit index.
  - Read hit: done=1, ReadData=arr_rdata, go to IDLE.
  - Read miss: go to REFILL.
  - Write hit: arr_we=1 at the hit index, arr_wdata=wdata_q, go to WRITE.
  - Write miss: go to WRITE with no array update.
- **REFILL**
  - Drive mem_req=1, mem_we=0, mem_addr=addr_q.
  - On mem_ack: arr_idx=ptr, arr_we=1, arr_wdata=mem_rdata. Set tag[ptr]=addr_q[31:3] and valid[ptr]=1.
  - In the same cycle: ptr advances by 1 modulo LINES, done=1, ReadData=mem_rdata, go to IDLE.
- **WRITE**
  - Drive mem_req=1, mem_we=1, mem_addr=addr_q, mem_wdata=wdata_q.
  - On mem_ack: done=1, go to IDLE.
- Output rules:
  - stall = (MemRead|MemWrite) & ~done.
  - ReadData is driven combinationally in the done cycle of a read. Otherwise it holds the last load result from an internal register.
  - mem_ack outside REFILL and WRITE is ignored.
  - arr_we is 0 in every cycle not listed above.
  - flush outside IDLE is ignored.

## Timing
- Values held in reset:
  - State IDLE, all valid bits 0, ptr 0, ReadData register 0.
  - done, stall, arr_we, mem_req and mem_we are all 0.
  - arr_idx, arr_wdata, mem_addr and mem_wdata are all 0.
- Reset mid-transaction: at the next edge, mem_req drops and the request is discarded with no array write. The pipeline must reissue the request.
- Read hit: accepted in cycle 0 (IDLE), done in cycle 1. stall is high for cycle 0 only.
- Read miss: done in the cycle mem_ack arrives. Total latency is 2 + N cycles, where N is the number of memory wait cycles.
- Write: same latency as a read miss. A hit writes the array in LOOKUP, one cycle before the memory request.
- While mem_req is high, mem_req, mem_we, mem_addr and mem_wdata are held stable until the ack cycle. mem_req drops in the cycle after ack.
- A back-to-back request is accepted in the IDLE cycle right after done, with no bubble beyond the single IDLE cycle.
- ptr wraps from LINES-1 to 0. A valid line at ptr is overwritten without writeback; this is safe because the cache is write-through.

## Test plan
- Reset, then a read of 0x00001010 with ack after 3 wait cycles, mem_rdata=0xDEADBEEF:
  - mem_req asserts with mem_addr=0x00001010; arr_we=1 at idx 0 in the ack cycle; ReadData=0xDEADBEEF; stall low after 5 cycles.
  - Reading the same address again then hits: done in cycle 1 with no mem_req.
- Write 0x12345678 to 0x00001010 (hit), then read it:
  - arr_we in LOOKUP at idx 0 with arr_wdata=0x12345678, then a memory write.
  - The read hits with ReadData=0x12345678.
- Write miss to 0x00002000:
  - A memory write occurs with arr_we never asserted.
  - A following read of 0x00002000 misses and refills.
- 17 read misses to distinct tags:
  - Lines fill idx 0..15, and the 17th miss refills idx 0 (ptr wrap).
  - A read of the first address then misses.
- flush together with MemRead in IDLE:
  - The request is accepted the next cycle, and all lines miss afterwards.
  - Also assert reset during REFILL: mem_req drops next cycle, no arr_we occurs, and valid stays cleared.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// Bundle of the pipeline load/store port, the cache data-array port and the
// main-memory port seen by the data-cache sequencing controller.
// "master" is the controller side (it masters the array and memory port and
// answers the pipeline); "slave" is the environment: pipeline, data array
// and memory.
interface dcache_ctrl_if #(
  parameter int LINES = 16
);
  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  // pipeline side
  logic             MemRead;
  logic             MemWrite;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             flush;
  logic [31:0]      ReadData;
  logic             stall;
  logic             done;

  // data-array side
  logic [IDX_W-1:0] arr_idx;
  logic             arr_we;
  logic [31:0]      arr_wdata;
  logic [31:0]      arr_rdata;

  // main-memory side
  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             mem_ack;

  modport master (
    input  MemRead, MemWrite, addr, wdata, flush,
    output ReadData, stall, done,
    output arr_idx, arr_we, arr_wdata,
    input  arr_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output MemRead, MemWrite, addr, wdata, flush,
    input  ReadData, stall, done,
    input  arr_idx, arr_we, arr_wdata,
    output arr_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Sequencing controller for a small fully associative, write-through,
// no-write-allocate data cache with one 32-bit word per line. It owns the
// tag/valid store, looks up each pipeline access, refills read misses into a
// round-robin victim line, writes every store through to memory and holds
// the pipeline until the access completes.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int TAG_W = 29
) (
  input  logic          clk,
  input  logic          reset,
  dcache_ctrl_if.master bus
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    WRITE  = 2'd3
  } state_t;

  // FSM
  state_t           state_r;
  state_t           nextState_s;

  // tag/valid store and victim pointer
  logic [TAG_W-1:0] tag_r [LINES];
  logic [LINES-1:0] valid_r;
  logic [IDX_W-1:0] ptr_r;

  // latched request and last load result
  logic             opWrite_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      readData_r;

  // lookup
  logic [TAG_W-1:0] reqTag_s;
  logic             hit_s;
  logic [IDX_W-1:0] hitIdx_s;

  // FSM decisions
  logic             accept_s;
  logic             flushNow_s;
  logic             fillNow_s;
  logic             done_s;
  logic             readDone_s;
  logic [31:0]      readDataNext_s;

  // raw (pre-reset-gating) output values
  logic [IDX_W-1:0] arrIdx_s;
  logic             arrWe_s;
  logic [31:0]      arrWdata_s;
  logic             memReq_s;
  logic             memWe_s;
  logic [31:0]      memAddr_s;
  logic [31:0]      memWdata_s;

  // The low three address bits select a byte within the word and never
  // take part in matching; they are still forwarded to memory untouched.
  assign reqTag_s = addr_r[31:32-TAG_W];

  // Associative match of the latched address against every valid line.
  // Tags are unique among valid lines, so OR-ing matching indices yields
  // the single hit index without a priority chain.
  always_comb begin
    hit_s    = 1'b0;
    hitIdx_s = {IDX_W{1'b0}};
    for (int i = 0; i < LINES; i++) begin
      if (valid_r[i] && (tag_r[i] == reqTag_s)) begin
        hit_s    = 1'b1;
        hitIdx_s = hitIdx_s | IDX_W'(i);
      end else begin
        hit_s    = hit_s;
      end
    end
  end

  // Next-state and output decode for IDLE/LOOKUP/REFILL/WRITE.
  always_comb begin
    nextState_s    = state_r;
    accept_s       = 1'b0;
    flushNow_s     = 1'b0;
    fillNow_s      = 1'b0;
    done_s         = 1'b0;
    readDone_s     = 1'b0;
    readDataNext_s = readData_r;
    arrIdx_s       = {IDX_W{1'b0}};
    arrWe_s        = 1'b0;
    arrWdata_s     = 32'd0;
    memReq_s       = 1'b0;
    memWe_s        = 1'b0;
    memAddr_s      = 32'd0;
    memWdata_s     = 32'd0;

    case (state_r)
      IDLE: begin
        if (bus.flush) begin
          // invalidate takes the whole cycle; a pending request waits
          flushNow_s  = 1'b1;
          nextState_s = IDLE;
        end else if (bus.MemRead || bus.MemWrite) begin
          accept_s    = 1'b1;
          nextState_s = LOOKUP;
        end else begin
          nextState_s = IDLE;
        end
      end

      LOOKUP: begin
        if (hit_s) begin
          arrIdx_s = hitIdx_s;
        end else begin
          arrIdx_s = {IDX_W{1'b0}};
        end
        if (opWrite_r) begin
          // write-through: update a present line now, memory follows
          if (hit_s) begin
            arrWe_s    = 1'b1;
            arrWdata_s = wdata_r;
          end else begin
            arrWe_s    = 1'b0;
          end
          nextState_s = WRITE;
        end else if (hit_s) begin
          done_s         = 1'b1;
          readDone_s     = 1'b1;
          readDataNext_s = bus.arr_rdata;
          nextState_s    = IDLE;
        end else begin
          nextState_s = REFILL;
        end
      end

      REFILL: begin
        memReq_s  = 1'b1;
        memWe_s   = 1'b0;
        memAddr_s = addr_r;
        if (bus.mem_ack) begin
          // victim at ptr is simply overwritten: memory already has its data
          arrIdx_s       = ptr_r;
          arrWe_s        = 1'b1;
          arrWdata_s     = bus.mem_rdata;
          fillNow_s      = 1'b1;
          done_s         = 1'b1;
          readDone_s     = 1'b1;
          readDataNext_s = bus.mem_rdata;
          nextState_s    = IDLE;
        end else begin
          nextState_s = REFILL;
        end
      end

      WRITE: begin
        memReq_s   = 1'b1;
        memWe_s    = 1'b1;
        memAddr_s  = addr_r;
        memWdata_s = wdata_r;
        if (bus.mem_ack) begin
          done_s      = 1'b1;
          nextState_s = IDLE;
        end else begin
          nextState_s = WRITE;
        end
      end

      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Tag/valid store and round-robin victim pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {LINES{1'b0}};
      ptr_r   <= {IDX_W{1'b0}};
      for (int i = 0; i < LINES; i++) begin
        tag_r[i] <= {TAG_W{1'b0}};
      end
    end else if (flushNow_s) begin
      valid_r <= {LINES{1'b0}};
    end else if (fillNow_s) begin
      valid_r[ptr_r] <= 1'b1;
      tag_r[ptr_r]   <= reqTag_s;
      // LINES is a power of two, so the natural wrap gives modulo LINES
      ptr_r          <= ptr_r + IDX_W'(1);
    end
  end

  // Request latch: captured once in IDLE; both strobes high means a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      opWrite_r <= 1'b0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
    end else if (accept_s) begin
      opWrite_r <= bus.MemWrite;
      addr_r    <= bus.addr;
      wdata_r   <= bus.wdata;
    end
  end

  // Last load result, presented on ReadData outside a load's done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      readData_r <= 32'd0;
    end else if (readDone_s) begin
      readData_r <= readDataNext_s;
    end
  end

  // While reset is asserted every output is forced quiet, so a transaction
  // interrupted by reset can neither complete nor write the array.
  assign bus.done      = done_s & ~reset;
  assign bus.stall     = (bus.MemRead | bus.MemWrite) & ~done_s & ~reset;
  assign bus.ReadData  = reset ? 32'd0 : readDataNext_s;
  assign bus.arr_idx   = reset ? {IDX_W{1'b0}} : arrIdx_s;
  assign bus.arr_we    = arrWe_s & ~reset;
  assign bus.arr_wdata = reset ? 32'd0 : arrWdata_s;
  assign bus.mem_req   = memReq_s & ~reset;
  assign bus.mem_we    = memWe_s & ~reset;
  assign bus.mem_addr  = reset ? 32'd0 : memAddr_s;
  assign bus.mem_wdata = reset ? 32'd0 : memWdata_s;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores/flushes, compared against a behavioural cache model
// (round-robin fill list plus a shadow main memory).
module tb_dcache_ctrl;
  localparam int LINES = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_ctrl_if #(.LINES(LINES)) bus ();

  dcache_ctrl #(.LINES(LINES), .TAG_W(29)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // data array: combinational read, written when the controller asks
  logic [31:0] arrMem [LINES];
  assign bus.arr_rdata = arrMem[bus.arr_idx];

  int checks   = 0;
  int failures = 0;

  // reference model
  bit          mValid [LINES];
  logic [28:0] mTag   [LINES];
  int          mPtr;
  logic [31:0] lastLoad;
  logic [31:0] mainMem [logic [28:0]];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int modelLookup(input logic [28:0] key);
    int idx;
    idx = -1;
    for (int i = 0; i < LINES; i++) begin
      if (mValid[i] && mTag[i] == key) idx = i;
    end
    return idx;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    mPtr     = 0;
    lastLoad = 32'd0;
  endtask

  task automatic checkQuiet(input string pfx);
    checkVal({pfx, "_done"},      bus.done,      32'd0);
    checkVal({pfx, "_stall"},     bus.stall,     32'd0);
    checkVal({pfx, "_arr_we"},    bus.arr_we,    32'd0);
    checkVal({pfx, "_mem_req"},   bus.mem_req,   32'd0);
    checkVal({pfx, "_mem_we"},    bus.mem_we,    32'd0);
    checkVal({pfx, "_arr_idx"},   bus.arr_idx,   32'd0);
    checkVal({pfx, "_arr_wdata"}, bus.arr_wdata, 32'd0);
    checkVal({pfx, "_mem_addr"},  bus.mem_addr,  32'd0);
    checkVal({pfx, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    checkVal({pfx, "_ReadData"},  bus.ReadData,  32'd0);
  endtask

  // One pipeline access, started at a negedge; returns at the negedge of the
  // IDLE cycle after done, so the next call issues back-to-back.
  task automatic access(input bit isWr, input bit both, input logic [31:0] a,
                        input logic [31:0] d, input bit fl, input int waitN);
    logic [28:0] key;
    logic [31:0] memVal;
    int hitIdx, fillIdx, off, waitLeft, expLat, expWeCyc, reqStart, cyc;
    bit needMem, finished;

    key = a[31:3];
    off = fl ? 1 : 0;
    if (fl) for (int i = 0; i < LINES; i++) mValid[i] = 1'b0;
    hitIdx   = modelLookup(key);
    fillIdx  = mPtr;
    waitLeft = (waitN < 0) ? int'($urandom_range(0, 3)) : waitN;
    if (!isWr && !mainMem.exists(key)) mainMem[key] = $urandom;
    memVal   = isWr ? d : mainMem[key];
    needMem  = isWr || (hitIdx < 0);
    expLat   = off + (needMem ? 2 + waitLeft : 1);
    reqStart = off + 2;
    expWeCyc = -1;
    if (!isWr && hitIdx < 0) expWeCyc = expLat;
    if (isWr && hitIdx >= 0) expWeCyc = off + 1;

    bus.MemRead  = !isWr || both;
    bus.MemWrite = isWr;
    bus.addr     = a;
    bus.wdata    = d;
    bus.flush    = fl;
    cyc      = 0;
    finished = 1'b0;
    while (!finished && cyc <= expLat + 4) begin
      #1;
      bus.mem_ack = 1'b0;
      checkVal("mem_req", bus.mem_req, needMem && cyc >= reqStart && cyc <= expLat);
      if (bus.mem_req) begin
        checkVal("mem_we", bus.mem_we, isWr);
        checkVal("mem_addr", bus.mem_addr, a);
        if (isWr) checkVal("mem_wdata", bus.mem_wdata, d);
        if (waitLeft == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = isWr ? $urandom : memVal;
        end else begin
          waitLeft--;
        end
      end
      #1;
      checkVal("done", bus.done, cyc == expLat);
      checkVal("stall", bus.stall, cyc != expLat);
      checkVal("arr_we", bus.arr_we, cyc == expWeCyc);
      if (bus.arr_we) begin
        checkVal("arr_idx", bus.arr_idx, isWr ? hitIdx : fillIdx);
        checkVal("arr_wdata", bus.arr_wdata, isWr ? d : memVal);
        arrMem[bus.arr_idx] = bus.arr_wdata;
      end
      if (!isWr && hitIdx >= 0 && cyc == off + 1) checkVal("hit_idx", bus.arr_idx, hitIdx);
      if (bus.done) begin
        finished = 1'b1;
        if (!isWr) checkVal("ReadData", bus.ReadData, memVal);
      end else begin
        checkVal("ReadData_hold", bus.ReadData, lastLoad);
      end
      @(negedge clk);
      bus.flush = 1'b0;
      cyc++;
    end
    bus.mem_ack  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    if (!finished) checkVal("timeout", 32'd0, 32'd1);

    // model update
    if (isWr) begin
      mainMem[key] = d;
    end else begin
      lastLoad = memVal;
      if (hitIdx < 0) begin
        mValid[mPtr] = 1'b1;
        mTag[mPtr]   = key;
        mPtr         = (mPtr + 1) % LINES;
      end
    end
  endtask

  // Reset asserted while a read miss waits in REFILL, with an ack racing it.
  task automatic resetDuringRefill(input logic [31:0] a);
    bus.MemRead = 1'b1;
    bus.addr    = a;
    bus.flush   = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkVal("rst_req_before", bus.mem_req, 32'd1);
    reset         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_5A5A;
    #1 checkVal("rst_arr_we_ack", bus.arr_we, 32'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1 checkQuiet("rst_mid");
    @(negedge clk);
    reset       = 1'b0;
    bus.MemRead = 1'b0;
    modelReset();
  endtask

  logic [31:0] addrs [17];
  logic [31:0] tmpA;

  initial begin
    reset         = 1'b1;
    bus.MemRead   = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    for (int i = 0; i < LINES; i++) arrMem[i] = $urandom;
    modelReset();

    repeat (3) @(negedge clk);
    #1 checkQuiet("reset");
    @(negedge clk);
    reset       = 1'b0;
    bus.MemRead = 1'b0;

    // read miss with 3 wait cycles, then the same address hits
    tmpA = 32'h0000_1010;
    mainMem[tmpA[31:3]] = 32'hDEAD_BEEF;
    access(1'b0, 1'b0, 32'h0000_1010, 32'd0, 1'b0, 3);
    access(1'b0, 1'b0, 32'h0000_1010, 32'd0, 1'b0, -1);
    // write hit then read back
    access(1'b1, 1'b0, 32'h0000_1010, 32'h1234_5678, 1'b0, 1);
    access(1'b0, 1'b0, 32'h0000_1010, 32'd0, 1'b0, -1);
    // write miss (no allocate) then the read misses
    access(1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 2);
    access(1'b0, 1'b0, 32'h0000_2000, 32'd0, 1'b0, 0);

    // reset in REFILL; 17 distinct misses (first one was cached before reset)
    resetDuringRefill(32'h0000_3000);
    for (int i = 0; i < 17; i++) begin
      addrs[i] = (i == 0) ? 32'h0000_1010 : 32'h0004_0000 + 32'(i) * 32'd8;
      access(1'b0, 1'b0, addrs[i], 32'd0, 1'b0, -1);
    end
    access(1'b0, 1'b0, addrs[0], 32'd0, 1'b0, -1);
    access(1'b0, 1'b0, addrs[10], 32'd0, 1'b0, -1);
    // flush with a pending read: one extra cycle, then everything misses
    access(1'b0, 1'b0, addrs[10], 32'd0, 1'b1, -1);
    access(1'b0, 1'b0, addrs[12], 32'd0, 1'b0, -1);

    // random traffic over a small address pool so hits, misses and evictions mix
    for (int n = 0; n < 250; n++) begin
      logic [31:0] ra;
      bit wr;
      ra = 32'h0008_0000 + 32'($urandom_range(0, 23)) * 32'd8 + 32'($urandom_range(0, 7));
      wr = ($urandom_range(0, 2) == 0);
      access(wr, wr && $urandom_range(0, 1) == 1, ra, $urandom,
             $urandom_range(0, 11) == 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
